// File: rtl/mem_rd_pkg.sv
// rtl/mem_rd_pkg.sv - shared state encoding and default sizing for the memory read controller
package mem_rd_pkg;

  localparam int unsigned DEF_DATA_W      = 32;
  localparam int unsigned DEF_ADDR_W      = 9;
  localparam int unsigned DEF_TIMEOUT_CYC = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } rd_state_t;

endpackage

// File: rtl/mem_rd_timer.sv
// rtl/mem_rd_timer.sv - load/enable/expire counter bounding how long a read may wait for mem_ack
module mem_rd_timer #(
  parameter int unsigned TIMEOUT_CYC = 16,
  localparam int unsigned CW = $clog2(TIMEOUT_CYC) + 1
) (
  input  logic clk,
  input  logic clr,
  input  logic load,
  input  logic en,
  output logic expire
);

  logic [CW-1:0] count;

  // Saturates rather than wrapping, so a stalled count can never re-fire.
  always_ff @(posedge clk) begin
    if (clr || load) begin
      count <= '0;
    end else if (en && (count != CW'(TIMEOUT_CYC))) begin
      count <= count + 1'b1;
    end
  end

  // Fires on the edge that would complete the TIMEOUT_CYC-th unacknowledged REQ cycle.
  assign expire = en && (count == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/mem_read_ctrl.sv
// rtl/mem_read_ctrl.sv - req/ack RAM read controller feeding the MDR mux
// Optional abort-on-timeout enabled by defining MEM_RD_TIMEOUT_EN.
module mem_read_ctrl
  import mem_rd_pkg::*;
#(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              rd_start,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              done,
  output logic              err
);

  rd_state_t state;
  logic      timeout_hit;

`ifdef MEM_RD_TIMEOUT_EN
  mem_rd_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk),
    .clr    (clr),
    .load   ((state == ST_IDLE) && rd_start),
    .en     ((state == ST_REQ) && !mem_ack),
    .expire (timeout_hit)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
  assign timeout_hit        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= ST_IDLE;
      mem_addr <= '0;
      mem_rd   <= 1'b0;
      data_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (rd_start) begin
            mem_addr <= rd_addr;
            mem_rd   <= 1'b1;
            err      <= 1'b0;
            busy     <= 1'b1;
            state    <= ST_REQ;
          end
        end
        ST_REQ: begin
          // Ack is checked first so a simultaneous timeout still completes the read.
          if (mem_ack) begin
            data_out <= mem_data;
            mem_rd   <= 1'b0;
            done     <= 1'b1;
            state    <= ST_DONE;
          end else if (timeout_hit) begin
            mem_rd <= 1'b0;
            err    <= 1'b1;
            done   <= 1'b1;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          mem_rd <= 1'b0;
          done   <= 1'b0;
          busy   <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_read_ctrl.sv
// tb/tb_mem_read_ctrl.sv - randomized self-checking bench for mem_read_ctrl against a transaction model
module tb_mem_read_ctrl;

  localparam int DW = 32;
  localparam int AW = 9;
  localparam int TO = 16;
`ifdef MEM_RD_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          clr;
  logic          rd_start;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic          mem_ack;
  logic [DW-1:0] mem_data;
  logic [DW-1:0] data_out;
  logic          busy;
  logic          done;
  logic          err;

  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic [DW-1:0] exp_data;
  logic          exp_err;
  int            n_checks = 0;
  int            n_errors = 0;

  mem_read_ctrl dut (
    .clk      (clk),
    .clr      (clr),
    .rd_start (rd_start),
    .rd_addr  (rd_addr),
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .mem_ack  (mem_ack),
    .mem_data (mem_data),
    .data_out (data_out),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One read: dly = number of REQ edges without ack before the RAM answers.
  // With the timeout build, the model aborts on the TO-th unacknowledged REQ edge.
  task automatic do_read(input logic [AW-1:0] addr, input int dly, input bit noise);
    bit abort;
    int n_wait;
    abort  = TO_EN && (dly >= TO);
    n_wait = abort ? TO - 1 : dly;
    rd_start = 1'b1;
    rd_addr  = addr;
    step();
    exp_err = 1'b0;
    check("req_busy", DW'(busy), 1);
    check("req_mem_rd", DW'(mem_rd), 1);
    check("req_addr", DW'(mem_addr), DW'(addr));
    check("req_err_cleared", DW'(err), 0);
    for (int i = 0; i < n_wait; i++) begin
      rd_start = noise ? 1'($urandom) : 1'b0;
      rd_addr  = AW'($urandom);
      mem_ack  = 1'b0;
      mem_data = $urandom;
      step();
      check("wait_mem_rd", DW'(mem_rd), 1);
      check("wait_addr", DW'(mem_addr), DW'(addr));
      check("wait_done", DW'(done), 0);
      check("wait_data_hold", data_out, exp_data);
    end
    rd_start = noise ? 1'($urandom) : 1'b0;
    rd_addr  = AW'($urandom);
    mem_ack  = !abort;
    mem_data = abort ? DW'($urandom) : ram[addr];
    step();
    mem_ack  = 1'b0;
    mem_data = $urandom;
    if (!abort) exp_data = ram[addr];
    exp_err = abort;
    check("fin_done", DW'(done), 1);
    check("fin_mem_rd", DW'(mem_rd), 0);
    check("fin_busy", DW'(busy), 1);
    check("fin_data", data_out, exp_data);
    check("fin_err", DW'(err), DW'(exp_err));
    rd_start = noise ? 1'b1 : 1'b0;
    step();
    rd_start = 1'b0;
    check("idle_done", DW'(done), 0);
    check("idle_busy", DW'(busy), 0);
    check("idle_mem_rd", DW'(mem_rd), 0);
    check("idle_err_held", DW'(err), DW'(exp_err));
    check("idle_data", data_out, exp_data);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) ram[i] = $urandom;
    ram[9'h005] = 32'hDEADBEEF;
    clr      = 1'b1;
    rd_start = 1'b0;
    rd_addr  = '0;
    mem_ack  = 1'b0;
    mem_data = '0;
    exp_data = '0;
    exp_err  = 1'b0;
    @(negedge clk);
    step();
    clr = 1'b0;

    // Reset state; mem_ack while idle must not capture anything.
    for (int i = 0; i < 5; i++) begin
      mem_ack  = (i == 2);
      mem_data = $urandom;
      step();
      check("rst_mem_rd", DW'(mem_rd), 0);
      check("rst_busy", DW'(busy), 0);
      check("rst_done", DW'(done), 0);
      check("rst_err", DW'(err), 0);
      check("rst_data", data_out, 0);
      check("rst_addr", DW'(mem_addr), 0);
    end
    mem_ack = 1'b0;

    do_read(9'h005, 0, 1'b0);
    check("first_data", data_out, 32'hDEADBEEF);

    if (TO_EN) begin
      do_read(9'h0A3, TO + 3, 1'b0);
      check("abort_keeps_data", data_out, 32'hDEADBEEF);
      check("abort_err", DW'(err), 1);
      do_read(9'h0A4, TO - 1, 1'b0);
      check("ack_beats_timeout_err", DW'(err), 0);
    end else begin
      do_read(9'h0A3, 3 * TO, 1'b0);
    end

    do_read(9'h1FF, 4, 1'b1);
    check("top_addr_data", data_out, ram[9'h1FF]);

    for (int n = 0; n < 40; n++) begin
      do_read(AW'($urandom), int'($urandom_range(0, TO + 4)), 1'($urandom));
    end

    // Reset in the middle of a read, then a stray ack.
    rd_start = 1'b1;
    rd_addr  = 9'h033;
    step();
    rd_start = 1'b0;
    step();
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    exp_data = '0;
    check("midclr_mem_rd", DW'(mem_rd), 0);
    check("midclr_busy", DW'(busy), 0);
    check("midclr_data", data_out, 0);
    check("midclr_addr", DW'(mem_addr), 0);
    mem_ack  = 1'b1;
    mem_data = 32'h12345678;
    step();
    mem_ack = 1'b0;
    check("late_ack_done", DW'(done), 0);
    check("late_ack_data", data_out, 0);
    check("late_ack_busy", DW'(busy), 0);

    do_read(9'h077, 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
